// File: rtl/instr_pkg.sv
// Shared definitions for the instruction sequencer: state encoding,
// instruction class / branch sub-op codes and instruction field positions.
package instr_pkg;

    localparam int IR_W   = 24;

    // Instruction field positions
    localparam int CLS_HI = 23;
    localparam int CLS_LO = 22;
    localparam int SUB_HI = 14;
    localparam int SUB_LO = 12;
    localparam int ST_BIT = 0;

    // Instruction classes, taken from ir[CLS_HI:CLS_LO]
    localparam logic [1:0] CLS_ALU = 2'b00;
    localparam logic [1:0] CLS_MOV = 2'b01;
    localparam logic [1:0] CLS_MEM = 2'b10;
    localparam logic [1:0] CLS_BR  = 2'b11;

    // Branch sub-ops, taken from ir[SUB_HI:SUB_LO]
    localparam logic [2:0] BR_CALL = 3'b011;
    localparam logic [2:0] BR_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALTED,
        S_FAULT
    } state_t;

endpackage

// File: rtl/wait_timer.sv
// Handshake watchdog: counts wait cycles of the current memory request and
// flags the last permitted wait cycle. Cleared on every state change so
// FETCH and MEM each start from zero.
module wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The count equals (wait cycle - 1); the last legal wait cycle is TIMEOUT.
    assign expired = (cnt_q == CW'(TIMEOUT - 1));

    // Next count: clear wins, otherwise advance while waiting, never past the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer. Holds the instruction register,
// drives the instruction/data memory handshakes and produces the per-state
// write enables and PC update controls for the datapath.
module instr_sequencer
    import instr_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [IR_W-1:0]  imem_data,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             cmp_true,
    output logic             imem_req,
    output logic [IR_W-1:0]  ir,
    output logic             ir_valid,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             flags_we,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instret
);

    state_t           state_q, state_d;
    logic [IR_W-1:0]  ir_q, ir_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [1:0] cls;
    logic [2:0] sub;
    logic       is_store;
    logic       is_call;

    logic rf_we_c, flags_we_c, pc_en_c, pc_sel_c;
    logic halt_ret;
    logic wait_en, wait_clr, wait_expired;

    assign cls      = ir_q[CLS_HI:CLS_LO];
    assign sub      = ir_q[SUB_HI:SUB_LO];
    assign is_store = ir_q[ST_BIT];
    assign is_call  = (cls == CLS_BR) && (sub == BR_CALL);

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (wait_clr),
        .en      (wait_en),
        .expired (wait_expired)
    );

    // Any state change restarts the watchdog, so each request waits from zero.
    assign wait_clr = (state_d != state_q);

    // Next-state, instruction register load and per-state control decode.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        rf_we_c    = 1'b0;
        flags_we_c = 1'b0;
        pc_en_c    = 1'b0;
        pc_sel_c   = 1'b0;
        halt_ret   = 1'b0;
        wait_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_d    = imem_data;
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d = S_FAULT;
                end else begin
                    wait_en = 1'b1;
                end
            end
            S_DECODE: begin
                state_d = (cls == CLS_MOV) ? S_WB : S_EXEC;
            end
            S_EXEC: begin
                case (cls)
                    CLS_ALU: state_d = S_WB;
                    CLS_MOV: state_d = S_WB;
                    CLS_MEM: state_d = S_MEM;
                    CLS_BR: begin
                        if (sub == BR_HALT) begin
                            halt_ret = 1'b1;
                            state_d  = S_HALTED;
                        end else if (sub == BR_CALL) begin
                            state_d  = S_WB;
                        end else begin
                            // Plain branch retires here; target chosen by the comparator.
                            pc_en_c  = 1'b1;
                            pc_sel_c = cmp_true;
                            state_d  = S_FETCH;
                        end
                    end
                    default: state_d = S_FAULT;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ready) begin
                    if (is_store) begin
                        // Stores have nothing to write back; retire on the handshake.
                        pc_en_c = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_expired) begin
                    state_d = S_FAULT;
                end else begin
                    wait_en = 1'b1;
                end
            end
            S_WB: begin
                rf_we_c    = 1'b1;
                flags_we_c = (cls == CLS_ALU);
                pc_en_c    = 1'b1;
                pc_sel_c   = is_call && cmp_true;
                state_d    = S_FETCH;
            end
            S_HALTED: state_d = S_HALTED;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Enables are suppressed in a reset cycle so an aborted instruction leaves no side effects.
    assign rf_we    = rf_we_c    && !reset;
    assign flags_we = flags_we_c && !reset;
    assign pc_en    = pc_en_c    && !reset;
    assign pc_sel   = pc_sel_c   && !reset;

    assign ir       = ir_q;
    assign ir_valid = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                      (state_q == S_MEM)    || (state_q == S_WB);
    assign halted   = (state_q == S_HALTED);
    assign fault    = (state_q == S_FAULT);
    assign instret  = instret_q;

    // Retired count: one per PC update plus one for the HALT that stops the machine.
    always_comb begin
        instret_d = instret_q;
        if (pc_en_c || halt_ret) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    // State, instruction register and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed vector table, hand-written
// HALT / timeout / reset sequences, and randomized instruction streams
// compared with a per-instruction cycle/enable model.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset, run, imem_ready, dmem_ready, cmp_true;
    logic [23:0] imem_data;
    logic        imem_req, ir_valid, dmem_req, dmem_we, rf_we, flags_we;
    logic        pc_en, pc_sel, halted, fault;
    logic [23:0] ir;
    logic [15:0] instret;

    int n_chk  = 0;
    int n_fail = 0;
    logic [15:0] exp_instret;

    instr_sequencer #(
        .TIMEOUT (16),
        .CNT_W   (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .imem_data  (imem_data),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .cmp_true   (cmp_true),
        .imem_req   (imem_req),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .rf_we      (rf_we),
        .flags_we   (flags_we),
        .pc_en      (pc_en),
        .pc_sel     (pc_sel),
        .halted     (halted),
        .fault      (fault),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 2000000");
        $fatal(1, "global timeout");
    end

    typedef struct {
        logic [23:0] word;
        logic        cmp;
        int          iw;
        int          dw;
        int          cyc;
        int          rf;
        int          fl;
        logic        ps;
        logic        dwe;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        imem_data = '0; cmp_true = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        exp_instret = '0;
    endtask

    task automatic start();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    // Expected cost of one instruction from the class rules: fetch takes iw+1
    // cycles, decode one, then the class-specific remainder.
    function automatic void model(input logic [23:0] w, input int iw, input int dw, input logic cmp,
                                  output int cyc, output int rf, output int fl,
                                  output logic ps, output logic dwe);
        int rest;
        rest = 0; rf = 0; fl = 0; ps = 1'b0; dwe = 1'b0;
        case (w[23:22])
            2'b00: begin rest = 2; rf = 1; fl = 1; end
            2'b01: begin rest = 1; rf = 1; end
            2'b10: begin
                if (w[0]) begin rest = dw + 2; dwe = 1'b1; end
                else      begin rest = dw + 3; rf = 1; end
            end
            default: begin
                if (w[14:12] == 3'b011) begin rest = 2; rf = 1; ps = cmp; end
                else                    begin rest = 1; ps = cmp; end
            end
        endcase
        cyc = iw + 2 + rest;
    endfunction

    // Acts as both memories for one instruction (ready after iw / dw wait cycles)
    // and records what the sequencer did until its PC update.
    task automatic run_instr(input logic [23:0] w, input int iw, input int dw, input logic cmp,
                             output int cyc, output int rf, output int fl, output logic ps,
                             output logic dwe, output logic [23:0] ir_at, output logic ok);
        int fw, mw;
        fw = 0; mw = 0; cyc = 0; rf = 0; fl = 0; ps = 1'b0; dwe = 1'b0; ir_at = '0; ok = 1'b0;
        cmp_true = cmp;
        for (int k = 0; k < 80 && !ok; k++) begin
            if (imem_req) begin
                imem_ready = (fw == iw);
                imem_data  = (fw == iw) ? w : 24'($urandom);
                fw++;
            end else begin
                imem_ready = 1'($urandom);
                imem_data  = 24'($urandom);
            end
            if (dmem_req) begin
                dmem_ready = (mw == dw);
                mw++;
            end else begin
                dmem_ready = 1'($urandom);
            end
            #4;
            cyc++;
            if (rf_we) rf++;
            if (flags_we) fl++;
            if (dmem_req && dmem_we) dwe = 1'b1;
            if (pc_en) begin
                ps    = pc_sel;
                ir_at = ir;
                ok    = 1'b1;
            end
            tick();
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
    endtask

    task automatic check_instr(input string tag, input vec_t v);
        int cyc, rf, fl;
        logic ps, dwe, ok;
        logic [23:0] ir_at;
        run_instr(v.word, v.iw, v.dw, v.cmp, cyc, rf, fl, ps, dwe, ir_at, ok);
        chk({tag, "_retired"}, 32'(ok), 32'd1);
        if (!ok) begin
            do_reset();
            start();
            return;
        end
        exp_instret = exp_instret + 16'd1;
        chk({tag, "_cycles"},   32'(cyc),   32'(v.cyc));
        chk({tag, "_rf_we"},    32'(rf),    32'(v.rf));
        chk({tag, "_flags_we"}, 32'(fl),    32'(v.fl));
        chk({tag, "_pc_sel"},   32'(ps),    32'(v.ps));
        chk({tag, "_dmem_we"},  32'(dwe),   32'(v.dwe));
        chk({tag, "_ir"},       32'(ir_at), 32'(v.word));
        chk({tag, "_instret"},  32'(instret), 32'(exp_instret));
    endtask

    initial begin
        vec_t vecs[12];
        vec_t rv;
        int   n;

        // word, cmp, iw, dw, cycles, rf_we count, flags_we count, pc_sel, dmem_we
        vecs[0]  = '{24'h000130, 1'b0, 0,  0,  4, 1, 1, 1'b0, 1'b0};
        vecs[1]  = '{24'h4000AB, 1'b1, 0,  0,  3, 1, 0, 1'b0, 1'b0};
        vecs[2]  = '{24'h800000, 1'b0, 0,  3,  8, 1, 0, 1'b0, 1'b0};
        vecs[3]  = '{24'h800001, 1'b0, 0,  0,  4, 0, 0, 1'b0, 1'b1};
        vecs[4]  = '{24'hC01000, 1'b1, 0,  0,  3, 0, 0, 1'b1, 1'b0};
        vecs[5]  = '{24'hC01000, 1'b0, 0,  0,  3, 0, 0, 1'b0, 1'b0};
        vecs[6]  = '{24'hC03000, 1'b1, 0,  0,  4, 1, 0, 1'b1, 1'b0};
        vecs[7]  = '{24'hC03000, 1'b0, 0,  0,  4, 1, 0, 1'b0, 1'b0};
        vecs[8]  = '{24'h000130, 1'b1, 2,  0,  6, 1, 1, 1'b0, 1'b0};
        vecs[9]  = '{24'h8ABCD1, 1'b0, 1,  2,  7, 0, 0, 1'b0, 1'b1};
        vecs[10] = '{24'h800000, 1'b0, 0, 15, 20, 1, 0, 1'b0, 1'b0};
        vecs[11] = '{24'hC02000, 1'b1, 0,  0,  3, 0, 0, 1'b1, 1'b0};

        // Reset values
        do_reset();
        #4;
        chk("reset_ctl", {20'd0, imem_req, ir_valid, dmem_req, dmem_we, rf_we, flags_we,
                          pc_en, pc_sel, halted, fault, 2'b00}, 32'd0);
        chk("reset_ir", 32'(ir), 32'd0);
        chk("reset_instret", 32'(instret), 32'd0);

        // Simultaneous reset and run: reset wins, machine stays idle
        tick();
        reset = 1'b1; run = 1'b1;
        tick();
        reset = 1'b0; run = 1'b0;
        #4;
        chk("reset_beats_run", 32'(imem_req), 32'd0);
        tick();
        #4;
        chk("idle_without_run", 32'(imem_req), 32'd0);
        tick();

        // Directed vector table, back to back
        start();
        #4;
        chk("first_fetch_req", 32'(imem_req), 32'd1);
        tick();
        do_reset();
        start();
        for (int i = 0; i < 12; i++) begin
            check_instr($sformatf("vec%0d", i), vecs[i]);
        end

        // HALT retires, then the machine stays halted
        cmp_true = 1'b0;
        imem_ready = 1'b1; imem_data = 24'hC07000;
        #4;
        chk("halt_fetch_req", 32'(imem_req), 32'd1);
        tick();
        imem_ready = 1'b0;
        #4;
        chk("halt_decode_valid", 32'(ir_valid), 32'd1);
        chk("halt_ir", 32'(ir), 32'hC07000);
        tick();
        #4;
        chk("halt_exec_not_yet", 32'({halted, pc_en}), 32'd0);
        tick();
        exp_instret = exp_instret + 16'd1;
        chk("halt_instret", 32'(instret), 32'(exp_instret));
        for (int i = 0; i < 4; i++) begin
            imem_ready = 1'($urandom); dmem_ready = 1'($urandom); run = 1'($urandom);
            #4;
            chk($sformatf("halted_hold%0d", i), 32'({halted, imem_req, ir_valid, pc_en}), 32'h8);
            tick();
        end
        chk("halted_instret_frozen", 32'(instret), 32'(exp_instret));

        // Data memory never answers: fault after exactly 16 MEM cycles
        do_reset();
        start();
        imem_ready = 1'b1; imem_data = 24'h800000;
        tick();
        imem_ready = 1'b0;
        tick();
        tick();
        n = 0;
        for (int k = 0; k < 40; k++) begin
            #4;
            if (!dmem_req) break;
            n++;
            tick();
        end
        chk("mem_timeout_cycles", 32'(n), 32'd16);
        chk("mem_timeout_fault", 32'(fault), 32'd1);
        tick();

        // Instruction memory never answers: fault after exactly 16 FETCH cycles
        do_reset();
        start();
        n = 0;
        for (int k = 0; k < 40; k++) begin
            #4;
            if (!imem_req) break;
            n++;
            tick();
        end
        chk("fetch_timeout_cycles", 32'(n), 32'd16);
        chk("fetch_timeout_fault", 32'(fault), 32'd1);
        tick();

        // Reset while a store waits in MEM
        do_reset();
        start();
        rv = '{24'h000130, 1'b0, 0, 0, 4, 1, 1, 1'b0, 1'b0};
        check_instr("pre_abort", rv);
        imem_ready = 1'b1; imem_data = 24'h800001;
        tick();
        imem_ready = 1'b0;
        tick();
        tick();
        #4;
        chk("abort_in_mem", 32'({dmem_req, dmem_we}), 32'h3);
        tick();
        reset = 1'b1; dmem_ready = 1'b1;
        #4;
        chk("abort_no_pulse", 32'({pc_en, rf_we, flags_we}), 32'd0);
        tick();
        reset = 1'b0; dmem_ready = 1'b0;
        exp_instret = '0;
        #4;
        chk("abort_ctl", {22'd0, imem_req, ir_valid, dmem_req, dmem_we, rf_we, flags_we,
                          pc_en, pc_sel, halted, fault}, 32'd0);
        chk("abort_ir", 32'(ir), 32'd0);
        chk("abort_instret", 32'(instret), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #4;
            chk($sformatf("abort_idle%0d", i), 32'(imem_req), 32'd0);
        end
        tick();
        start();
        #4;
        chk("abort_restart_fetch", 32'(imem_req), 32'd1);
        tick();

        // Randomized instruction stream against the model
        do_reset();
        start();
        for (int i = 0; i < 80; i++) begin
            rv.word = 24'($urandom);
            if (rv.word[23:22] == 2'b11 && rv.word[14:12] == 3'b111) rv.word[14:12] = 3'b101;
            rv.iw  = int'($urandom_range(0, 3));
            rv.dw  = int'($urandom_range(0, 4));
            rv.cmp = 1'($urandom);
            model(rv.word, rv.iw, rv.dw, rv.cmp, rv.cyc, rv.rf, rv.fl, rv.ps, rv.dwe);
            check_instr($sformatf("rnd%0d", i), rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
